// File: rtl/wavetable_requester_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wavetable_requester_if                                    |
// | Purpose  : Request/return bundle between the wavetable requester     |
// |            and the shared wavetable ROM sharer.                      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface wavetable_requester_if #(
  parameter int NUM_VOICES = 32
);
  logic [NUM_VOICES-1:0] req_valid;  // one-hot (or zero) request per voice
  logic [9:0]            req_addr;   // ROM address shared by all voices
  logic [4:0]            rd_sel;     // voice whose sharer output is captured
  logic [17:0]           rd_data;    // selected sharer output, signed

  modport master (
    output req_valid,
    output req_addr,
    output rd_sel,
    input  rd_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rd_sel,
    output rd_data
  );
endinterface
`default_nettype wire

// File: rtl/wavetable_requester.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wavetable_requester                                       |
// | Purpose  : Walks all voices on each sample tick, advances per-voice  |
// |            phase accumulators, issues one-hot ROM requests and sums |
// |            the returned samples into one signed mix word per frame. |
// | Options  : WT_REQ_PIPELINE_EN - overlap wait/capture with issue so   |
// |            each voice takes one cycle (default: serial 3-cycle walk)|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module wavetable_requester #(
  parameter int NUM_VOICES = 32,
  parameter int ACC_W      = 20,
  parameter int MIX_W      = 18 + $clog2(NUM_VOICES)
) (
  input  wire                     clk,
  input  wire                     rst,
  input  wire                     sample_tick,
  input  wire  [NUM_VOICES-1:0]   voice_en,
  input  wire                     inc_we,
  input  wire  [4:0]              inc_voice,
  input  wire  [ACC_W-1:0]        inc_value,
  wavetable_requester_if.master   rom,
  output logic [MIX_W-1:0]        mix_out,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int c_VOICE_W = 5;
  localparam int c_ADDR_W  = 10;
  localparam int c_DATA_W  = 18;

  // Per-voice state
  logic [ACC_W-1:0]      r_acc [NUM_VOICES];
  logic [ACC_W-1:0]      r_inc [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_en;

  // Frame accumulation and held outputs
  logic [MIX_W-1:0]      r_sum;
  logic [MIX_W-1:0]      w_sum_next;
  logic [MIX_W-1:0]      r_mix_out;
  logic [MIX_W-1:0]      w_rd_ext;
  logic                  r_mix_valid;
  logic                  r_overrun;
  logic [c_ADDR_W-1:0]   r_addr_hold;
  logic [c_ADDR_W-1:0]   w_req_addr;
  logic [c_VOICE_W-1:0]  r_rd_sel_hold;
  logic [c_VOICE_W-1:0]  w_rd_sel;
  logic [NUM_VOICES-1:0] w_req_valid;

  // Control strobes produced by whichever sequencer is built
  logic                  w_start;
  logic                  w_issue;
  logic [c_VOICE_W-1:0]  w_issue_voice;
  logic                  w_capture;
  logic [c_VOICE_W-1:0]  w_cap_voice;
  logic                  w_to_done;
  logic                  w_busy;

  assign w_rd_ext = {{(MIX_W-c_DATA_W){rom.rd_data[c_DATA_W-1]}}, rom.rd_data};

`ifdef WT_REQ_PIPELINE_EN
  // One voice slot per cycle; a two-stage shadow pipe tracks which voice's
  // sharer output lands two cycles after its request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [c_VOICE_W:0] c_NUM_SLOTS = (c_VOICE_W+1)'(NUM_VOICES);
  localparam logic [c_VOICE_W:0] c_LAST_CNT  = (c_VOICE_W+1)'(NUM_VOICES + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [c_VOICE_W:0]   r_cnt;
  logic                 r_p1_v;
  logic                 r_p2_v;
  logic [c_VOICE_W-1:0] r_p1_voice;
  logic [c_VOICE_W-1:0] r_p2_voice;

  // State register, slot counter and shadow pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_p1_v     <= 1'b0;
      r_p2_v     <= 1'b0;
      r_p1_voice <= '0;
      r_p2_voice <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_cnt  <= '0;
        r_p1_v <= 1'b0;
        r_p2_v <= 1'b0;
      end else begin
        if (r_state == S_RUN) begin
          r_cnt <= r_cnt + (c_VOICE_W+1)'(1);
        end
        r_p1_v     <= w_issue;
        r_p1_voice <= w_issue_voice;
        r_p2_v     <= r_p1_v;
        r_p2_voice <= r_p1_voice;
      end
    end
  end

  // Next state and per-cycle issue/capture strobes
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_issue       = 1'b0;
    w_issue_voice = r_cnt[c_VOICE_W-1:0];
    w_capture     = 1'b0;
    w_cap_voice   = r_p2_voice;
    w_to_done     = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_tick) begin
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt < c_NUM_SLOTS) begin
          w_issue = r_en[w_issue_voice];
        end
        w_capture = r_p2_v;
        if (r_cnt == c_LAST_CNT) begin
          w_to_done    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end
`else
  // Serial walk: an enabled voice costs issue, wait and capture cycles; a
  // disabled voice costs a single issue cycle with no request.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_VOICE_W-1:0] r_voice;
  logic                 w_last;
  logic                 w_advance;

  assign w_last = (r_voice == c_VOICE_W'(NUM_VOICES - 1));

  // State register and current voice index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_voice <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_voice <= '0;
      end else if (w_advance) begin
        r_voice <= r_voice + c_VOICE_W'(1);
      end
    end
  end

  // Next state and per-cycle issue/capture strobes
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_issue       = 1'b0;
    w_issue_voice = r_voice;
    w_capture     = 1'b0;
    w_cap_voice   = r_voice;
    w_to_done     = 1'b0;
    w_busy        = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sample_tick) begin
          w_start      = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_busy = 1'b1;
        if (r_en[r_voice]) begin
          w_issue      = 1'b1;
          w_state_next = S_WAIT;
        end else if (w_last) begin
          w_to_done    = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_advance    = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_WAIT: begin
        w_busy       = 1'b1;
        w_state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_busy    = 1'b1;
        w_capture = 1'b1;
        if (w_last) begin
          w_to_done    = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_advance    = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end
`endif

  // Request/capture datapath: address and read select hold when idle
  always_comb begin
    w_req_valid = '0;
    w_req_addr  = r_addr_hold;
    w_rd_sel    = r_rd_sel_hold;
    w_sum_next  = r_sum;
    if (w_issue) begin
      w_req_valid[w_issue_voice] = 1'b1;
      w_req_addr = r_acc[w_issue_voice][ACC_W-1 -: c_ADDR_W];
    end
    if (w_capture) begin
      w_rd_sel   = w_cap_voice;
      w_sum_next = r_sum + w_rd_ext;
    end
  end

  // Phase accumulators advance on issue; increment writes take effect next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_acc[v] <= '0;
        r_inc[v] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_acc[w_issue_voice] <= r_acc[w_issue_voice] + r_inc[w_issue_voice];
      end
      if (inc_we && (int'(inc_voice) < NUM_VOICES)) begin
        r_inc[inc_voice] <= inc_value;
      end
    end
  end

  // Frame bookkeeping: enables, running sum, mix result and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en          <= '0;
      r_sum         <= '0;
      r_mix_out     <= '0;
      r_mix_valid   <= 1'b0;
      r_overrun     <= 1'b0;
      r_addr_hold   <= '0;
      r_rd_sel_hold <= '0;
    end else begin
      r_mix_valid <= w_to_done;
      if (w_start) begin
        r_en  <= voice_en;
        r_sum <= '0;
      end else if (w_capture) begin
        r_sum <= w_sum_next;
      end
      if (w_to_done) begin
        r_mix_out <= w_sum_next;
      end
      if (sample_tick && w_busy) begin
        r_overrun <= 1'b1;
      end
      if (w_issue) begin
        r_addr_hold <= w_req_addr;
      end
      if (w_capture) begin
        r_rd_sel_hold <= w_cap_voice;
      end
    end
  end

  assign rom.req_valid = w_req_valid;
  assign rom.req_addr  = w_req_addr;
  assign rom.rd_sel    = w_rd_sel;
  assign mix_out       = r_mix_out;
  assign mix_valid     = r_mix_valid;
  assign busy          = w_busy;
  assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_wavetable_requester.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_wavetable_requester                                    |
// | Purpose  : Scoreboard bench for wavetable_requester with a sharer    |
// |            model, a frame-level reference model and random frames.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_wavetable_requester;
  localparam int NV    = 32;
  localparam int ACC_W = 20;
  localparam int MIX_W = 23;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_tick = 1'b0;
  logic [NV-1:0]    voice_en = '0;
  logic             inc_we = 1'b0;
  logic [4:0]       inc_voice = '0;
  logic [ACC_W-1:0] inc_value = '0;
  logic [MIX_W-1:0] mix_out;
  logic             mix_valid;
  logic             busy;
  logic             overrun;

  wavetable_requester_if #(.NUM_VOICES(NV)) bus ();

  wavetable_requester #(.NUM_VOICES(NV), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .inc_we      (inc_we),
    .inc_voice   (inc_voice),
    .inc_value   (inc_value),
    .rom         (bus),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ROM contents: either a constant or a function of voice and address
  int          rom_mode  = 0;
  logic [17:0] rom_const = '0;

  function automatic logic [17:0] rom_val(input int v, input logic [9:0] a);
    logic [4:0] vv;
    vv = v[4:0];
    if (rom_mode == 1) return rom_const;
    return {a[7:0], a} ^ {vv, 13'h0};
  endfunction

  function automatic int onehot_idx(input logic [NV-1:0] x);
    int r = 0;
    for (int i = 0; i < NV; i++) if (x[i]) r = i;
    return r;
  endfunction

  // Sharer model: ROM read register then per-voice output register
  logic [17:0] sh_out [NV];
  logic        s1_v = 1'b0;
  logic [4:0]  s1_voice = '0;
  logic [9:0]  s1_addr = '0;
  always @(posedge clk) begin
    s1_v     <= |bus.req_valid;
    s1_voice <= 5'(onehot_idx(bus.req_valid));
    s1_addr  <= bus.req_addr;
    if (s1_v) sh_out[s1_voice] <= rom_val(int'(s1_voice), s1_addr);
  end
  assign bus.rd_data = sh_out[bus.rd_sel];

  // Reference model and scoreboard queues
  logic [ACC_W-1:0] m_acc [NV];
  logic [ACC_W-1:0] m_inc [NV];

  typedef struct { int cyc; int voice; int addr; } req_t;
  typedef struct { int cyc; int voice; } cap_t;
  typedef struct { int cyc; logic [MIX_W-1:0] val; } mix_t;
  req_t req_q[$];
  cap_t cap_q[$];
  mix_t mix_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares requests, capture selects and mix results as they appear
  req_t mon_r;
  cap_t mon_c;
  mix_t mon_m;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid != '0) begin
        check("req_onehot", $countones(bus.req_valid), 1);
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got %0h expected none (cycle %0d)", bus.req_valid, cyc);
        end else begin
          mon_r = req_q.pop_front();
          check("req_cycle", cyc, mon_r.cyc);
          check("req_voice", onehot_idx(bus.req_valid), mon_r.voice);
          check("req_addr", bus.req_addr, mon_r.addr);
        end
      end
      if (cap_q.size() != 0 && cap_q[0].cyc == cyc) begin
        mon_c = cap_q.pop_front();
        check("rd_sel", bus.rd_sel, mon_c.voice);
      end
      if (mix_valid) begin
        if (mix_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_mix: got %0h expected none (cycle %0d)", mix_out, cyc);
        end else begin
          mon_m = mix_q.pop_front();
          check("mix_cycle", cyc, mon_m.cyc);
          check("mix_out", mix_out, mon_m.val);
          check("busy_at_mix", busy, 0);
        end
      end
    end
  end

  // Push the whole expected frame, then pulse the tick (call at a negedge)
  task automatic start_frame(input logic [NV-1:0] en);
    int base = cyc;
    int t = base + 1;
    int sum = 0;
    logic [9:0] a;
    for (int v = 0; v < NV; v++) begin
`ifdef WT_REQ_PIPELINE_EN
      t = base + 1 + v;
`endif
      if (en[v]) begin
        a = m_acc[v][ACC_W-1:ACC_W-10];
        req_q.push_back('{t, v, int'(a)});
        cap_q.push_back('{t + 2, v});
        sum += int'($signed(rom_val(v, a)));
        m_acc[v] = m_acc[v] + m_inc[v];
        t += 3;
      end else begin
        t += 1;
      end
    end
`ifdef WT_REQ_PIPELINE_EN
    t = base + 35;
`endif
    mix_q.push_back('{t, MIX_W'(sum)});
    voice_en    = en;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("busy_start", busy, 1);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (mix_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (mix_q.size() != 0) begin
      total++; bad++;
      $display("FAIL frame_timeout: got no mix_valid expected one within 400 cycles");
      mix_q.delete(); req_q.delete(); cap_q.delete();
    end
    @(negedge clk);
    check("req_drained", req_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic write_inc(input int v, input logic [ACC_W-1:0] val);
    inc_we    = 1'b1;
    inc_voice = 5'(v);
    inc_value = val;
    @(negedge clk);
    inc_we = 1'b0;
    m_inc[v] = val;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_valid"}, bus.req_valid, 0);
    check({tag, "_req_addr"}, bus.req_addr, 0);
    check({tag, "_rd_sel"}, bus.rd_sel, 0);
    check({tag, "_mix_out"}, mix_out, 0);
    check({tag, "_mix_valid"}, mix_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int v = 0; v < NV; v++) begin
      sh_out[v] = '0;
      m_acc[v]  = '0;
      m_inc[v]  = '0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // All voices disabled: empty frame
    start_frame('0);
    wait_frame();

    // Single voice 5 stepping one address per frame
    write_inc(5, 20'h00400);
    repeat (4) begin
      start_frame(32'h0000_0020);
      wait_frame();
    end

    // Voice 0 wraps the accumulator
    write_inc(0, 20'h80000);
    repeat (3) begin
      start_frame(32'h0000_0001);
      wait_frame();
    end

    // All voices with constant samples: -1 and +1
    rom_mode  = 1;
    rom_const = 18'h3FFFF;
    start_frame('1);
    wait_frame();
    rom_const = 18'h00001;
    start_frame('1);
    wait_frame();
    rom_mode = 0;

    // Random increments and enables
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) write_inc(int'($urandom_range(0, NV - 1)), ACC_W'($urandom));
      start_frame(NV'($urandom));
      wait_frame();
    end

    // Tick during a busy frame is ignored and flags overrun
    check("overrun_before", overrun, 0);
    start_frame('1);
    repeat (49) @(negedge clk);
    voice_en    = NV'($urandom);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    wait_frame();
    check("overrun_set", overrun, 1);
    start_frame(NV'($urandom));
    wait_frame();
    check("overrun_sticky", overrun, 1);

    // Asynchronous reset in the middle of a frame
    start_frame('1);
    repeat (39) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    req_q.delete(); cap_q.delete(); mix_q.delete();
    for (int v = 0; v < NV; v++) begin
      m_acc[v] = '0;
      m_inc[v] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    check("busy_after_reset", busy, 0);

    // Clean frames after reset start from zeroed accumulators
    write_inc(3, 20'h12345);
    start_frame(32'h0000_0028);
    wait_frame();
    start_frame(32'h0000_0028);
    wait_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wavetable_requester.md
# wavetable_requester

Initiator side of the shared wavetable ROM port. On each audio sample tick it walks all voices (16 channels × right/left = 32 requesters), keeps a phase accumulator per voice, and drives one-hot `valid_addr` and address requests into `wavetable_sharer`. It collects the returned 18-bit samples and emits their signed sum as one mix word per frame. It replaces the ad-hoc per-channel request logic and guarantees at most one valid per cycle, so the sharer's `error` never fires.

## Interface
- `NUM_VOICES`, 32: requester count; voice v maps to ch(v/2), r if v even, l if odd.
- `ACC_W`, 20: phase accumulator width; ROM address = `acc[ACC_W-1:ACC_W-10]`.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `sample_tick` in 1: frame start strobe, one cycle.
- `voice_en` in NUM_VOICES: per-voice enable, sampled on accepted tick.
- `inc_we` in 1: phase increment write strobe.
- `inc_voice` in 5: voice index for write.
- `inc_value` in ACC_W: phase increment value.
- `req_valid` out NUM_VOICES: one-hot (or zero) request, drives `chN_x_valid_addr`.
- `req_addr` out 10: address, fanned to every `chN_x_addr`.
- `rd_sel` out 5: voice whose sharer output register is being captured; top muxes `chN_x_out` by it.
- `rd_data` in 18: selected sharer output, signed two's complement.
- `mix_out` out 18+clog2(NUM_VOICES) (23): signed frame sum.
- `mix_valid` out 1: one-cycle strobe, `mix_out` valid.
- `busy` out 1: frame in progress.
- `overrun` out 1: sticky, tick arrived while busy.

## Operation
- Reset (async): all outputs 0; accumulators, increments, latched enables, and running sum 0; FSM IDLE.
- FSM: IDLE → ISSUE → WAIT → CAPTURE → (next voice ISSUE | DONE) → IDLE.
- IDLE: on `sample_tick`, latch `voice_en`, clear sum, set voice=0, go to ISSUE.
- ISSUE: if voice enabled, `req_valid[voice]=1` and `req_addr=acc[voice]` top 10 bits for exactly 1 cycle. `acc[voice] += inc[voice]` mod 2^ACC_W. Go to WAIT. If disabled, no request and no accumulator update; advance the voice, or go to DONE after the last voice (1 cycle).
- WAIT: 1 cycle (ROM read plus sharer `_d` register).
- CAPTURE: `rd_sel=voice`; sum += sign-extended `rd_data`; advance the voice.
- DONE: `mix_out<=sum`, `mix_valid=1` for 1 cycle; go to IDLE.
- `req_addr` holds its last value when there is no request. `rd_sel` holds its last value.
- `inc_we`: writes `inc[inc_voice]` at the clock edge; the value is used from the next ISSUE of that voice. A write in the same cycle as that voice's ISSUE uses the old value. Indices ≥ NUM_VOICES are ignored.
- `sample_tick` while `busy`: ignored and `overrun<=1`. `overrun` clears only on reset.
- Sum width: no overflow possible; no saturation.

## Timing
- Tick sampled at edge E0. `busy` is high from cycle 1 until DONE's cycle and low in the cycle `mix_valid` is high.
- Enabled voice: request cycle k, `rd_data` sampled end of cycle k+2, next voice ISSUE k+3.
- All 32 enabled: requests at cycles 1,4,…,94; last capture cycle 96; `mix_valid` cycle 97. All disabled: `mix_valid` cycle 33.
- A tick coincident with `mix_valid` (FSM back in IDLE next cycle) is accepted only from the cycle after DONE.
- Reset mid-frame: all state cleared immediately, no `mix_valid`, next tick starts a clean frame.

## Configuration
- `WT_REQ_PIPELINE_EN` defined: WAIT/CAPTURE are overlapped with the issue stream, giving one voice slot per cycle.
  - Voice v requests in cycle v+1 if enabled.
  - A 2-deep shadow pipe carries voice index and enable; capture happens at slot+2, with `rd_sel` driven from the pipe.
  - With 32 voices, the last capture is cycle 34 and `mix_valid` is cycle 35, regardless of enables.
- Undefined: the serial 3-cycle FSM above.

## Test plan
- Reset: assert `rst` async mid-cycle → every output 0 immediately. Release, then tick with all voices disabled → `mix_valid` at cycle 33, `mix_out=0`, no `req_valid`.
- Single voice 5 enabled, `inc=0x00400`, four ticks → `req_valid=0x20` with `req_addr` 0,1,2,3. Check `rd_sel=5` at capture.
- Wrap: voice 0 `inc=0x80000`, three ticks → `req_addr` 0,512,0.
- All 32 enabled, `rd_data=18'h3FFFF` → `mix_out=-32` (23'h7FFFE0) at cycle 97. With `rd_data=1` → 32. Check one-hot on every cycle.
- Tick at cycle 50 of a frame → `overrun=1`, frame completes unchanged, a later tick is accepted normally. Async reset at cycle 40 → no `mix_valid`, accumulators 0.
- With `WT_REQ_PIPELINE_EN`, all enabled → requests cycles 1..32 back-to-back one-hot, `mix_valid` cycle 35, same sum as the serial build.
